// File: rtl/fba_pkg.sv
// Shared constants for the framebuffer write arbiter: FSM state codes and clip counter width.
package fba_pkg;

  localparam int unsigned CLIP_CNT_W = 16;

  localparam logic [0:0] ST_DRAW  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the lowest valid index at or above the pointer, wrapping.
module fb_rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NREQ-1:0] valid_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_c_o
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0] ptr_q, ptr_d;
  logic            found_c;
  logic [PTRW-1:0] gidx_c;

  // Search from the pointer upward first, then wrap to the indices below it.
  always_comb begin
    grant_c_o = '0;
    found_c   = 1'b0;
    gidx_c    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found_c && valid_i[i] && (i >= int'(ptr_q))) begin
        found_c      = 1'b1;
        grant_c_o[i] = 1'b1;
        gidx_c       = PTRW'(i);
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found_c && valid_i[i] && (i < int'(ptr_q))) begin
        found_c      = 1'b1;
        grant_c_o[i] = 1'b1;
        gidx_c       = PTRW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found_c) begin
      ptr_d = (int'(gidx_c) == int'(NREQ) - 1) ? '0 : gidx_c + PTRW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port among NREQ drawing engines with clipping and address mapping.
// Optional full-buffer clear sequencer is built when FBA_CLEAR_EN is defined.
module fb_write_arbiter
  import fba_pkg::*;
#(
  parameter  int unsigned NREQ      = 2,
  parameter  int unsigned CORDW     = 16,
  parameter  int unsigned FB_WIDTH  = 160,
  parameter  int unsigned FB_HEIGHT = 120,
  parameter  int unsigned FB_DATAW  = 1,
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT,
  localparam int unsigned FB_ADDRW  = $clog2(FB_PIXELS)
) (
  input  logic                     clk_pix,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*CORDW-1:0]    req_x,
  input  logic [NREQ*CORDW-1:0]    req_y,
  input  logic [NREQ*FB_DATAW-1:0] req_colr,
  input  logic                     clear_req,
  input  logic [FB_DATAW-1:0]      clear_colr,
  output logic                     clear_busy,
  output logic                     fb_we,
  output logic [FB_ADDRW-1:0]      fb_addr,
  output logic [FB_DATAW-1:0]      fb_colr,
  output logic [CLIP_CNT_W-1:0]    clip_cnt
);

  localparam int unsigned MULW = 2 * CORDW;

  logic [0:0]            state_q, state_d;
  logic                  fb_we_q, fb_we_d;
  logic [FB_ADDRW-1:0]   fb_addr_q, fb_addr_d;
  logic [FB_DATAW-1:0]   fb_colr_q, fb_colr_d;
  logic                  busy_q, busy_d;
  logic [CLIP_CNT_W-1:0] clip_q, clip_d;

  logic                  clear_start_c;
  logic [FB_DATAW-1:0]   clear_colr_c;
  logic                  draw_en_c;
  logic [NREQ-1:0]       grant_c;
  logic [CORDW-1:0]      sel_x_c, sel_y_c;
  logic [FB_DATAW-1:0]   sel_colr_c;
  logic                  in_range_c;
  logic [MULW-1:0]       lin_addr_c;

`ifdef FBA_CLEAR_EN
  assign clear_start_c = clear_req;
  assign clear_colr_c  = clear_colr;
`else
  logic unused_clear;
  assign unused_clear  = ^{clear_req, clear_colr};
  assign clear_start_c = 1'b0;
  assign clear_colr_c  = '0;
`endif

  // A clear request pre-empts every requester in the cycle it arrives.
  assign draw_en_c = (state_q == ST_DRAW) && !clear_start_c;

  fb_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i     (clk_pix),
    .rst_n_i   (rst_n),
    .valid_i   (req_valid),
    .en_i      (draw_en_c),
    .grant_c_o (grant_c)
  );

  assign req_ready = draw_en_c ? grant_c : '0;

  always_comb begin
    sel_x_c    = '0;
    sel_y_c    = '0;
    sel_colr_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_c[i]) begin
        sel_x_c    = req_x[i*CORDW +: CORDW];
        sel_y_c    = req_y[i*CORDW +: CORDW];
        sel_colr_c = req_colr[i*FB_DATAW +: FB_DATAW];
      end
    end
  end

  // Sign bit clear means non-negative, so the unsigned upper-bound compare is safe.
  assign in_range_c = !sel_x_c[CORDW-1] && (sel_x_c < CORDW'(FB_WIDTH)) &&
                      !sel_y_c[CORDW-1] && (sel_y_c < CORDW'(FB_HEIGHT));
  assign lin_addr_c = MULW'(sel_y_c) * MULW'(FB_WIDTH) + MULW'(sel_x_c);

  always_comb begin
    state_d   = state_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_colr_d = fb_colr_q;
    busy_d    = busy_q;
    clip_d    = clip_q;
    case (state_q)
      ST_DRAW: begin
        if (clear_start_c) begin
          state_d   = ST_CLEAR;
          fb_we_d   = 1'b1;
          fb_addr_d = '0;
          fb_colr_d = clear_colr_c;
          busy_d    = 1'b1;
        end else if (|grant_c) begin
          if (in_range_c) begin
            fb_we_d   = 1'b1;
            fb_addr_d = FB_ADDRW'(lin_addr_c);
            fb_colr_d = sel_colr_c;
          end else if (clip_q != '1) begin
            clip_d = clip_q + CLIP_CNT_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        if (fb_addr_q == FB_ADDRW'(FB_PIXELS - 1)) begin
          state_d = ST_DRAW;
          busy_d  = 1'b0;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_addr_q + FB_ADDRW'(1);
        end
      end
      default: state_d = ST_DRAW;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state_q   <= ST_DRAW;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_colr_q <= '0;
      busy_q    <= 1'b0;
      clip_q    <= '0;
    end else begin
      state_q   <= state_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_colr_q <= fb_colr_d;
      busy_q    <= busy_d;
      clip_q    <= clip_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_colr    = fb_colr_q;
  assign clear_busy = busy_q;
  assign clip_cnt   = clip_q;

endmodule
